// File: rtl/alu_rs_if.sv
// alu_rs_if : bundle between the ALU reservation station and its neighbours.
//   Dispatch_*          : new instruction offered by the dispatch unit
//   RS_Full             : every reservation-station entry is busy
//   CDB_ALU_* / CDB_LSB_*: result broadcasts snooped for operand wakeup
//   ALU_S, Op, Vj, Vk, Reorder, A, pc : registered issue to the ALU
// master = dispatch/CDB side (and ALU consumer), slave = the reservation station.
interface alu_rs_if;
  logic        Dispatch_S;
  logic [5:0]  Dispatch_Op;
  logic [31:0] Dispatch_Vj;
  logic [31:0] Dispatch_Vk;
  logic        Dispatch_Qj_S;
  logic        Dispatch_Qk_S;
  logic [3:0]  Dispatch_Qj;
  logic [3:0]  Dispatch_Qk;
  logic [3:0]  Dispatch_Reorder;
  logic [31:0] Dispatch_A;
  logic [31:0] Dispatch_pc;
  logic        RS_Full;

  logic        CDB_ALU_S;
  logic [3:0]  CDB_ALU_Reorder;
  logic [31:0] CDB_ALU_Value;
  logic        CDB_LSB_S;
  logic [3:0]  CDB_LSB_Reorder;
  logic [31:0] CDB_LSB_Value;

  logic        ALU_S;
  logic [5:0]  Op;
  logic [31:0] Vj;
  logic [31:0] Vk;
  logic [3:0]  Reorder;
  logic [31:0] A;
  logic [31:0] pc;

  modport slave (
    input  Dispatch_S, Dispatch_Op, Dispatch_Vj, Dispatch_Vk,
           Dispatch_Qj_S, Dispatch_Qk_S, Dispatch_Qj, Dispatch_Qk,
           Dispatch_Reorder, Dispatch_A, Dispatch_pc,
           CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value,
           CDB_LSB_S, CDB_LSB_Reorder, CDB_LSB_Value,
    output RS_Full, ALU_S, Op, Vj, Vk, Reorder, A, pc
  );

  modport master (
    output Dispatch_S, Dispatch_Op, Dispatch_Vj, Dispatch_Vk,
           Dispatch_Qj_S, Dispatch_Qk_S, Dispatch_Qj, Dispatch_Qk,
           Dispatch_Reorder, Dispatch_A, Dispatch_pc,
           CDB_ALU_S, CDB_ALU_Reorder, CDB_ALU_Value,
           CDB_LSB_S, CDB_LSB_Reorder, CDB_LSB_Value,
    input  RS_Full, ALU_S, Op, Vj, Vk, Reorder, A, pc
  );
endinterface

// File: rtl/alu_rs.sv
// alu_rs : reservation station in front of the ALU.
//   clk_in  : system clock, rising edge
//   rst_in  : asynchronous active-high reset
//   rdy_in  : global ready, low freezes all entry state and issue
//   Clear   : mispredict flush, empties every entry (works even when rdy_in=0)
//   rs_bus  : dispatch, CDB snoop and ALU issue signals (alu_rs_if.slave)
// Entries are selected purely by index: dispatch fills the lowest free entry,
// issue takes the lowest entry whose operands are both available.
module alu_rs #(
  parameter int RS_SIZE = 8
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     Clear,
  alu_rs_if.slave  rs_bus
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] r_busy;
  logic [RS_SIZE-1:0] r_qj_s;
  logic [RS_SIZE-1:0] r_qk_s;
  logic [5:0]         r_op      [RS_SIZE];
  logic [31:0]        r_vj      [RS_SIZE];
  logic [31:0]        r_vk      [RS_SIZE];
  logic [3:0]         r_qj      [RS_SIZE];
  logic [3:0]         r_qk      [RS_SIZE];
  logic [3:0]         r_reorder [RS_SIZE];
  logic [31:0]        r_a       [RS_SIZE];
  logic [31:0]        r_pc      [RS_SIZE];

  logic        r_alu_s;
  logic [5:0]  r_op_out;
  logic [31:0] r_vj_out;
  logic [31:0] r_vk_out;
  logic [3:0]  r_reorder_out;
  logic [31:0] r_a_out;
  logic [31:0] r_pc_out;

  logic               w_full;
  logic [RS_SIZE-1:0] w_ready;
  logic [IDX_W-1:0]   w_free_idx;
  logic [IDX_W-1:0]   w_iss_idx;
  logic               w_iss_vld;
  logic               w_disp_acc;
  logic               w_disp_qj_s;
  logic               w_disp_qk_s;
  logic [31:0]        w_disp_vj;
  logic [31:0]        w_disp_vk;

  assign w_full     = &r_busy;
  assign w_ready    = r_busy & ~r_qj_s & ~r_qk_s;
  assign w_iss_vld  = |w_ready;
  assign w_disp_acc = rs_bus.Dispatch_S & ~w_full;

  // Descending scan so the last assignment wins with the lowest index.
  always_comb begin
    w_free_idx = '0;
    w_iss_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = IDX_W'(i);
      if (w_ready[i]) w_iss_idx  = IDX_W'(i);
    end
  end

  // Same-cycle bypass for dispatched operands; ALU CDB wins over LSB CDB.
  always_comb begin
    w_disp_vj   = rs_bus.Dispatch_Vj;
    w_disp_qj_s = 1'b0;
    if (rs_bus.Dispatch_Qj_S) begin
      if (rs_bus.CDB_ALU_S && rs_bus.CDB_ALU_Reorder == rs_bus.Dispatch_Qj)
        w_disp_vj = rs_bus.CDB_ALU_Value;
      else if (rs_bus.CDB_LSB_S && rs_bus.CDB_LSB_Reorder == rs_bus.Dispatch_Qj)
        w_disp_vj = rs_bus.CDB_LSB_Value;
      else
        w_disp_qj_s = 1'b1;
    end
    w_disp_vk   = rs_bus.Dispatch_Vk;
    w_disp_qk_s = 1'b0;
    if (rs_bus.Dispatch_Qk_S) begin
      if (rs_bus.CDB_ALU_S && rs_bus.CDB_ALU_Reorder == rs_bus.Dispatch_Qk)
        w_disp_vk = rs_bus.CDB_ALU_Value;
      else if (rs_bus.CDB_LSB_S && rs_bus.CDB_LSB_Reorder == rs_bus.Dispatch_Qk)
        w_disp_vk = rs_bus.CDB_LSB_Value;
      else
        w_disp_qk_s = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy        <= '0;
      r_qj_s        <= '0;
      r_qk_s        <= '0;
      r_alu_s       <= 1'b0;
      r_op_out      <= '0;
      r_vj_out      <= '0;
      r_vk_out      <= '0;
      r_reorder_out <= '0;
      r_a_out       <= '0;
      r_pc_out      <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i]      <= '0;
        r_vj[i]      <= '0;
        r_vk[i]      <= '0;
        r_qj[i]      <= '0;
        r_qk[i]      <= '0;
        r_reorder[i] <= '0;
        r_a[i]       <= '0;
        r_pc[i]      <= '0;
      end
    end else if (Clear) begin
      r_busy  <= '0;
      r_alu_s <= 1'b0;
    end else if (!rdy_in) begin
      r_alu_s <= 1'b0;
    end else begin
      // Wakeup only touches entries that were busy before the edge; the entry
      // being dispatched is free, so the two never write the same slot.
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && r_qj_s[i]) begin
          if (rs_bus.CDB_ALU_S && rs_bus.CDB_ALU_Reorder == r_qj[i]) begin
            r_vj[i]   <= rs_bus.CDB_ALU_Value;
            r_qj_s[i] <= 1'b0;
          end else if (rs_bus.CDB_LSB_S && rs_bus.CDB_LSB_Reorder == r_qj[i]) begin
            r_vj[i]   <= rs_bus.CDB_LSB_Value;
            r_qj_s[i] <= 1'b0;
          end
        end
        if (r_busy[i] && r_qk_s[i]) begin
          if (rs_bus.CDB_ALU_S && rs_bus.CDB_ALU_Reorder == r_qk[i]) begin
            r_vk[i]   <= rs_bus.CDB_ALU_Value;
            r_qk_s[i] <= 1'b0;
          end else if (rs_bus.CDB_LSB_S && rs_bus.CDB_LSB_Reorder == r_qk[i]) begin
            r_vk[i]   <= rs_bus.CDB_LSB_Value;
            r_qk_s[i] <= 1'b0;
          end
        end
      end

      // Issue uses pre-edge state; data outputs hold when nothing issues.
      if (w_iss_vld) begin
        r_alu_s           <= 1'b1;
        r_op_out          <= r_op[w_iss_idx];
        r_vj_out          <= r_vj[w_iss_idx];
        r_vk_out          <= r_vk[w_iss_idx];
        r_reorder_out     <= r_reorder[w_iss_idx];
        r_a_out           <= r_a[w_iss_idx];
        r_pc_out          <= r_pc[w_iss_idx];
        r_busy[w_iss_idx] <= 1'b0;
      end else begin
        r_alu_s <= 1'b0;
      end

      // The issuing entry is busy and the free entry is not, so these differ.
      if (w_disp_acc) begin
        r_busy[w_free_idx]    <= 1'b1;
        r_op[w_free_idx]      <= rs_bus.Dispatch_Op;
        r_vj[w_free_idx]      <= w_disp_vj;
        r_qj_s[w_free_idx]    <= w_disp_qj_s;
        r_qj[w_free_idx]      <= rs_bus.Dispatch_Qj;
        r_vk[w_free_idx]      <= w_disp_vk;
        r_qk_s[w_free_idx]    <= w_disp_qk_s;
        r_qk[w_free_idx]      <= rs_bus.Dispatch_Qk;
        r_reorder[w_free_idx] <= rs_bus.Dispatch_Reorder;
        r_a[w_free_idx]       <= rs_bus.Dispatch_A;
        r_pc[w_free_idx]      <= rs_bus.Dispatch_pc;
      end
    end
  end

  assign rs_bus.RS_Full = w_full;
  assign rs_bus.ALU_S   = r_alu_s;
  assign rs_bus.Op      = r_op_out;
  assign rs_bus.Vj      = r_vj_out;
  assign rs_bus.Vk      = r_vk_out;
  assign rs_bus.Reorder = r_reorder_out;
  assign rs_bus.A       = r_a_out;
  assign rs_bus.pc      = r_pc_out;

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;

  localparam int N = 8;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic Clear;

  alu_rs_if bus();

  alu_rs #(.RS_SIZE(N)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .Clear  (Clear),
    .rs_bus (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        busy;
    logic [5:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic        qjs;
    logic        qks;
    logic [3:0]  qj;
    logic [3:0]  qk;
    logic [3:0]  rob;
    logic [31:0] a;
    logic [31:0] pc;
  } ent_t;

  ent_t m [N];
  logic        e_alu_s;
  logic [5:0]  e_op;
  logic [31:0] e_vj, e_vk, e_a, e_pc;
  logic [3:0]  e_rob;

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [138:0] obs, logic [138:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m[i] = '0;
    e_alu_s = 0; e_op = 0; e_vj = 0; e_vk = 0; e_rob = 0; e_a = 0; e_pc = 0;
  endtask

  function automatic logic model_full();
    for (int i = 0; i < N; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Operand resolution against the live CDBs: {still_pending, value}.
  function automatic logic [32:0] res(logic pend, logic [3:0] tag, logic [31:0] v);
    if (!pend) return {1'b0, v};
    if (bus.CDB_ALU_S && bus.CDB_ALU_Reorder == tag) return {1'b0, bus.CDB_ALU_Value};
    if (bus.CDB_LSB_S && bus.CDB_LSB_Reorder == tag) return {1'b0, bus.CDB_LSB_Value};
    return {1'b1, v};
  endfunction

  task automatic model_step();
    ent_t pre [N];
    int iss, fr;
    logic full;
    logic [32:0] r;
    if (rst_in) begin model_reset(); return; end
    if (Clear) begin
      for (int i = 0; i < N; i++) m[i].busy = 0;
      e_alu_s = 0;
      return;
    end
    if (!rdy_in) begin e_alu_s = 0; return; end
    pre = m; iss = -1; fr = -1; full = 1;
    for (int i = 0; i < N; i++) begin
      if (!pre[i].busy) begin
        full = 0;
        if (fr < 0) fr = i;
      end else if (!pre[i].qjs && !pre[i].qks && iss < 0) iss = i;
    end
    for (int i = 0; i < N; i++) if (pre[i].busy) begin
      r = res(pre[i].qjs, pre[i].qj, pre[i].vj); m[i].qjs = r[32]; m[i].vj = r[31:0];
      r = res(pre[i].qks, pre[i].qk, pre[i].vk); m[i].qks = r[32]; m[i].vk = r[31:0];
    end
    if (iss >= 0) begin
      e_alu_s = 1; e_op = pre[iss].op; e_vj = pre[iss].vj; e_vk = pre[iss].vk;
      e_rob = pre[iss].rob; e_a = pre[iss].a; e_pc = pre[iss].pc;
      m[iss].busy = 0;
    end else e_alu_s = 0;
    if (bus.Dispatch_S && !full) begin
      m[fr].busy = 1; m[fr].op = bus.Dispatch_Op; m[fr].qj = bus.Dispatch_Qj;
      m[fr].qk = bus.Dispatch_Qk; m[fr].rob = bus.Dispatch_Reorder;
      m[fr].a = bus.Dispatch_A; m[fr].pc = bus.Dispatch_pc;
      r = res(bus.Dispatch_Qj_S, bus.Dispatch_Qj, bus.Dispatch_Vj); m[fr].qjs = r[32]; m[fr].vj = r[31:0];
      r = res(bus.Dispatch_Qk_S, bus.Dispatch_Qk, bus.Dispatch_Vk); m[fr].qks = r[32]; m[fr].vk = r[31:0];
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_out"}, {bus.ALU_S, bus.Op, bus.Vj, bus.Vk, bus.Reorder, bus.A, bus.pc},
        {e_alu_s, e_op, e_vj, e_vk, e_rob, e_a, e_pc});
    chk({tag, "_full"}, 139'(bus.RS_Full), 139'(model_full()));
  endtask

  task automatic tick(string tag);
    @(posedge clk_in);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    bus.Dispatch_S = 0; bus.Dispatch_Op = 0; bus.Dispatch_Vj = 0; bus.Dispatch_Vk = 0;
    bus.Dispatch_Qj_S = 0; bus.Dispatch_Qk_S = 0; bus.Dispatch_Qj = 0; bus.Dispatch_Qk = 0;
    bus.Dispatch_Reorder = 0; bus.Dispatch_A = 0; bus.Dispatch_pc = 0;
    bus.CDB_ALU_S = 0; bus.CDB_ALU_Reorder = 0; bus.CDB_ALU_Value = 0;
    bus.CDB_LSB_S = 0; bus.CDB_LSB_Reorder = 0; bus.CDB_LSB_Value = 0;
  endtask

  task automatic disp(logic [5:0] op, logic [31:0] vj, logic qjs, logic [3:0] qj,
                      logic [31:0] vk, logic qks, logic [3:0] qk, logic [3:0] rob,
                      logic [31:0] a, logic [31:0] pc);
    bus.Dispatch_S = 1; bus.Dispatch_Op = op; bus.Dispatch_Vj = vj; bus.Dispatch_Qj_S = qjs;
    bus.Dispatch_Qj = qj; bus.Dispatch_Vk = vk; bus.Dispatch_Qk_S = qks; bus.Dispatch_Qk = qk;
    bus.Dispatch_Reorder = rob; bus.Dispatch_A = a; bus.Dispatch_pc = pc;
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; Clear = 0;
    idle();
    model_reset();
    #2;
    check_all("rst0");
    tick("rst1");
    tick("rst2");
    rst_in = 0;

    // Scenario 1: ready ADDI issues one edge after dispatch.
    disp(6'h13, 32'd5, 0, 0, 32'd0, 0, 0, 4'd1, 32'd7, 32'h100);
    tick("s1_d");
    chk("s1_full", 139'(bus.RS_Full), 139'(0));
    idle();
    tick("s1_i");
    chk("s1_alus", 139'(bus.ALU_S), 139'(1));
    chk("s1_vj", 139'(bus.Vj), 139'(5));
    chk("s1_a", 139'(bus.A), 139'(7));
    chk("s1_rob", 139'(bus.Reorder), 139'(1));
    tick("s1_z");
    chk("s1_once", 139'(bus.ALU_S), 139'(0));

    // Scenario 2: LSB CDB wakeup two cycles after dispatch.
    disp(6'h33, 32'd0, 1, 4'd3, 32'd11, 0, 0, 4'd2, 32'd0, 32'h104);
    tick("s2_d");
    idle();
    tick("s2_wait");
    bus.CDB_LSB_S = 1; bus.CDB_LSB_Reorder = 4'd3; bus.CDB_LSB_Value = 32'h1234;
    tick("s2_w");
    chk("s2_not_yet", 139'(bus.ALU_S), 139'(0));
    idle();
    tick("s2_i");
    chk("s2_alus", 139'(bus.ALU_S), 139'(1));
    chk("s2_vj", 139'(bus.Vj), 139'(32'h1234));

    // Scenario 3: dispatch bypass from the ALU CDB.
    disp(6'h33, 32'd20, 0, 0, 32'd0, 1, 4'd6, 4'd4, 32'd0, 32'h108);
    bus.CDB_ALU_S = 1; bus.CDB_ALU_Reorder = 4'd6; bus.CDB_ALU_Value = 32'd9;
    tick("s3_d");
    idle();
    tick("s3_i");
    chk("s3_alus", 139'(bus.ALU_S), 139'(1));
    chk("s3_vk", 139'(bus.Vk), 139'(9));

    // Scenario 4: fill, ignored dispatch, wake entry 2, refill entry 2.
    for (int i = 0; i < N; i++) begin
      disp(6'h01, 32'd0, 1, 4'(8 + i), 32'(i), 0, 0, 4'(i), 32'(i), 32'(i * 4));
      tick("s4_fill");
    end
    chk("s4_full", 139'(bus.RS_Full), 139'(1));
    disp(6'h02, 32'd1, 0, 0, 32'd2, 0, 0, 4'd9, 32'd3, 32'h200);
    tick("s4_ign");
    chk("s4_ign_alus", 139'(bus.ALU_S), 139'(0));
    idle();
    bus.CDB_ALU_S = 1; bus.CDB_ALU_Reorder = 4'd10; bus.CDB_ALU_Value = 32'hAA;
    tick("s4_w");
    idle();
    tick("s4_i");
    chk("s4_rob", 139'(bus.Reorder), 139'(2));
    chk("s4_drop", 139'(bus.RS_Full), 139'(0));
    disp(6'h03, 32'd1, 0, 0, 32'd2, 0, 0, 4'd12, 32'd3, 32'h300);
    tick("s4_re");
    chk("s4_refull", 139'(bus.RS_Full), 139'(1));
    idle();
    tick("s4_ri");
    chk("s4_ri_rob", 139'(bus.Reorder), 139'(12));

    // Asynchronous reset in the middle of operation.
    rst_in = 1;
    #1;
    model_reset();
    check_all("rst_async");
    tick("rst_hold");
    rst_in = 0;

    // Scenario 5: Clear with 4 busy entries and a simultaneous dispatch.
    for (int i = 0; i < 4; i++) begin
      disp(6'h04, 32'd0, 1, 4'(i + 1), 32'd0, 0, 0, 4'(i + 1), 32'd0, 32'(i));
      tick("s5_fill");
    end
    disp(6'h05, 32'd1, 0, 0, 32'd1, 0, 0, 4'd7, 32'd0, 32'h400);
    Clear = 1;
    tick("s5_clr");
    chk("s5_full", 139'(bus.RS_Full), 139'(0));
    Clear = 0;
    for (int t = 1; t <= 4; t++) begin
      idle();
      bus.CDB_ALU_S = 1; bus.CDB_ALU_Reorder = 4'(t); bus.CDB_ALU_Value = 32'(t * 16);
      tick("s5_b");
      chk("s5_noiss", 139'(bus.ALU_S), 139'(0));
    end
    idle();
    tick("s5_end");
    chk("s5_noiss2", 139'(bus.ALU_S), 139'(0));

    // Scenario 6: rdy_in low freezes issue and capture.
    disp(6'h06, 32'd0, 1, 4'd7, 32'd0, 0, 0, 4'd6, 32'd0, 32'h500);
    tick("s6_d0");
    disp(6'h07, 32'h55, 0, 0, 32'd0, 0, 0, 4'd5, 32'd0, 32'h504);
    tick("s6_d1");
    idle();
    rdy_in = 0;
    bus.CDB_ALU_S = 1; bus.CDB_ALU_Reorder = 4'd7; bus.CDB_ALU_Value = 32'h77;
    for (int t = 0; t < 3; t++) begin
      tick("s6_frz");
      chk("s6_frz_alus", 139'(bus.ALU_S), 139'(0));
    end
    rdy_in = 1;
    idle();
    tick("s6_i");
    chk("s6_rob5", 139'(bus.Reorder), 139'(5));
    chk("s6_alus", 139'(bus.ALU_S), 139'(1));
    tick("s6_nocap");
    chk("s6_nocap_alus", 139'(bus.ALU_S), 139'(0));
    bus.CDB_ALU_S = 1; bus.CDB_ALU_Reorder = 4'd7; bus.CDB_ALU_Value = 32'h78;
    tick("s6_w");
    idle();
    tick("s6_i2");
    chk("s6_vj", 139'(bus.Vj), 139'(32'h78));

    // Randomized traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      bus.Dispatch_S       = ($urandom_range(0, 99) < 60);
      bus.Dispatch_Op      = 6'($urandom);
      bus.Dispatch_Vj      = $urandom;
      bus.Dispatch_Vk      = $urandom;
      bus.Dispatch_Qj_S    = ($urandom_range(0, 99) < 50);
      bus.Dispatch_Qk_S    = ($urandom_range(0, 99) < 50);
      bus.Dispatch_Qj      = 4'($urandom);
      bus.Dispatch_Qk      = 4'($urandom);
      bus.Dispatch_Reorder = 4'($urandom);
      bus.Dispatch_A       = $urandom;
      bus.Dispatch_pc      = $urandom;
      bus.CDB_ALU_S        = ($urandom_range(0, 99) < 40);
      bus.CDB_ALU_Reorder  = 4'($urandom);
      bus.CDB_ALU_Value    = $urandom;
      bus.CDB_LSB_S        = ($urandom_range(0, 99) < 40);
      bus.CDB_LSB_Reorder  = 4'($urandom);
      bus.CDB_LSB_Value    = $urandom;
      rdy_in               = ($urandom_range(0, 99) < 90);
      Clear                = ($urandom_range(0, 99) < 3);
      tick("rnd");
    end
    Clear = 0;
    rdy_in = 1;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
